// File: rtl/bpu_upd_ctrl_pkg.sv
// rtl/bpu_upd_ctrl_pkg.sv - shared widths, FSM encoding and payload helper for bpu_upd_ctrl
package bpu_upd_ctrl_pkg;

  localparam int PC_W                = 32;
  localparam int BPU_UPD_W           = 40;
  localparam int BPU_UPD_TAKEN_TGT_W = 30;
  localparam int UPD_PART_W          = BPU_UPD_W - BPU_UPD_TAKEN_TGT_W;

  // Cleared PHT entries read as weak not-taken (2'b01) and cleared BTB entries
  // as invalid; the predictor supplies that data, this block only sequences it.
  typedef enum logic {
    BPU_UC_CLEAR = 1'b0,
    BPU_UC_RUN   = 1'b1
  } bpu_uc_state_e;

  // Payload = {is_bcc, is_breg, is_brel, taken, tag pc, actual npc, partial upd}
  function automatic int bpu_upd_payload_w(input int btb_p_num);
    return 4 + (PC_W - btb_p_num) + PC_W + UPD_PART_W;
  endfunction

endpackage

// File: rtl/bpu_upd_ctrl_fifo.sv
// rtl/bpu_upd_ctrl_fifo.sv - multi-push, single-pop update FIFO with lane compaction
module bpu_upd_fifo
  import bpu_upd_ctrl_pkg::*;
#(
  parameter int NL      = 2,
  parameter int P_DEPTH = 2,
  parameter int W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [NL-1:0]     push_valid,
  input  logic [NL*W-1:0]   push_data,
  input  logic              pop,
  output logic [W-1:0]      head,
  output logic [P_DEPTH:0]  count
);

  localparam int D = 1 << P_DEPTH;

  logic [W-1:0]         mem [D];
  logic [P_DEPTH-1:0]   wr_ptr;
  logic [P_DEPTH-1:0]   rd_ptr;
  logic [P_DEPTH-1:0]   slot [NL];
  logic [P_DEPTH-1:0]   slot_off;
  logic [P_DEPTH:0]     n_push;

  // Compact valid lanes: each lane lands after all lower valid lanes.
  always_comb begin
    slot_off = '0;
    n_push   = '0;
    for (int i = 0; i < NL; i++) begin
      slot[i]  = wr_ptr + slot_off;
      slot_off = slot_off + P_DEPTH'(push_valid[i]);
      n_push   = n_push + (P_DEPTH+1)'(push_valid[i]);
    end
  end

  // Storage write; entries are don't-care until pointed at by rd_ptr.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NL; i++) begin
      if (push_valid[i]) mem[slot[i]] <= push_data[i*W +: W];
    end
  end

  // Modulo-D pointers and occupancy; a pop frees its slot for the next cycle only.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_push[P_DEPTH-1:0];
      if (pop) rd_ptr <= rd_ptr + P_DEPTH'(1);
      count  <= count + n_push - (P_DEPTH+1)'(pop);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/bpu_upd_ctrl.sv
// rtl/bpu_upd_ctrl.sv - predictor training scheduler and table-clear sequencer (option: BPU_UPD_DROP_EN)
module bpu_upd_ctrl
  import bpu_upd_ctrl_pkg::*;
#(
  parameter int CONFIG_PHT_P_NUM      = 9,
  parameter int CONFIG_BTB_P_NUM      = 9,
  parameter int CONFIG_P_COMMIT_WIDTH = 1,
  parameter int CONFIG_P_UPD_FIFO     = 2,
  localparam int NL    = 1 << CONFIG_P_COMMIT_WIDTH,
  localparam int TAG_W = PC_W - CONFIG_BTB_P_NUM,
  localparam int SW    = (CONFIG_PHT_P_NUM > CONFIG_BTB_P_NUM) ? CONFIG_PHT_P_NUM : CONFIG_BTB_P_NUM
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush_req,
  input  logic [NL-1:0]            cmt_valid,
  input  logic [NL-1:0]            cmt_is_bcc,
  input  logic [NL-1:0]            cmt_is_breg,
  input  logic [NL-1:0]            cmt_is_brel,
  input  logic [NL-1:0]            cmt_taken,
  input  logic [NL*TAG_W-1:0]      cmt_pc,
  input  logic [NL*PC_W-1:0]       cmt_npc_act,
  input  logic [NL*UPD_PART_W-1:0] cmt_upd,
  output logic                     cmt_ready,
  output logic                     bpu_wb,
  output logic                     bpu_wb_is_bcc,
  output logic                     bpu_wb_is_breg,
  output logic                     bpu_wb_is_brel,
  output logic                     bpu_wb_taken,
  output logic [TAG_W-1:0]         bpu_wb_pc,
  output logic [PC_W-1:0]          bpu_wb_npc_act,
  output logic [UPD_PART_W-1:0]    bpu_wb_upd_partial,
  output logic                     init_we,
  output logic                     init_pht_we,
  output logic                     init_btb_we,
  output logic [SW-1:0]            init_addr,
  output logic                     bpu_busy
`ifdef BPU_UPD_DROP_EN
  ,
  output logic [15:0]              drop_cnt
`endif
);

  localparam int D     = 1 << CONFIG_P_UPD_FIFO;
  localparam int CW    = CONFIG_P_UPD_FIFO + 1;
  localparam int PW    = bpu_upd_payload_w(CONFIG_BTB_P_NUM);
  localparam int PHT_N = 1 << CONFIG_PHT_P_NUM;
  localparam int BTB_N = 1 << CONFIG_BTB_P_NUM;
  localparam logic [SW-1:0] IDX_LAST = '1;

  bpu_uc_state_e    state, state_nxt;
  logic [SW-1:0]    idx, idx_nxt;
  logic [CW-1:0]    fifo_cnt;
  logic [PW-1:0]    fifo_head;
  logic [NL*PW-1:0] push_data;
  logic [NL-1:0]    lane_br;
  logic [NL-1:0]    lane_push;
  logic             in_run;
  logic             fifo_pop;
  int               room_left;

  assign in_run  = (state == BPU_UC_RUN);
  assign lane_br = cmt_is_bcc | cmt_is_breg | cmt_is_brel;

`ifdef BPU_UPD_DROP_EN
  assign cmt_ready = in_run;
`else
  assign cmt_ready = in_run & ((D - int'(fifo_cnt)) >= NL) & ~flush_req;
`endif

  // Select lanes to enqueue in lane order; lanes beyond free space are dropped (oldest kept).
  always_comb begin
    lane_push = '0;
    room_left = D - int'(fifo_cnt);
    for (int i = 0; i < NL; i++) begin
      if (cmt_valid[i] && cmt_ready && !flush_req && lane_br[i] && room_left > 0) begin
        lane_push[i] = 1'b1;
        room_left    = room_left - 1;
      end
    end
  end

  // Pack per-lane payload for the FIFO.
  always_comb begin
    push_data = '0;
    for (int i = 0; i < NL; i++) begin
      push_data[i*PW +: PW] = {cmt_is_bcc[i], cmt_is_breg[i], cmt_is_brel[i], cmt_taken[i],
                               cmt_pc[i*TAG_W +: TAG_W], cmt_npc_act[i*PC_W +: PC_W],
                               cmt_upd[i*UPD_PART_W +: UPD_PART_W]};
    end
  end

  assign fifo_pop = in_run & (fifo_cnt != '0) & ~flush_req;

  bpu_upd_fifo #(
    .NL      (NL),
    .P_DEPTH (CONFIG_P_UPD_FIFO),
    .W       (PW)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clr        (flush_req),
    .push_valid (lane_push),
    .push_data  (push_data),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .count      (fifo_cnt)
  );

  // Clear/run state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= BPU_UC_CLEAR;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Clear walks every index once; a flush (re)starts the walk from 0.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      BPU_UC_CLEAR: begin
        if (flush_req) begin
          idx_nxt = '0;
        end else if (idx == IDX_LAST) begin
          idx_nxt   = '0;
          state_nxt = BPU_UC_RUN;
        end else begin
          idx_nxt = idx + SW'(1);
        end
      end
      BPU_UC_RUN: begin
        if (flush_req) begin
          idx_nxt   = '0;
          state_nxt = BPU_UC_CLEAR;
        end
      end
      default: ;
    endcase
  end

  // Registered clear strobes; busy also covers the flush cycle so fetch never sees a gap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      init_we     <= 1'b0;
      init_pht_we <= 1'b0;
      init_btb_we <= 1'b0;
      init_addr   <= '0;
      bpu_busy    <= 1'b1;
    end else begin
      init_we     <= ~in_run;
      init_pht_we <= ~in_run & (int'(idx) < PHT_N);
      init_btb_we <= ~in_run & (int'(idx) < BTB_N);
      init_addr   <= in_run ? '0 : idx;
      bpu_busy    <= ~in_run | (state_nxt == BPU_UC_CLEAR);
    end
  end

  // Serialized write-back register; payload holds between pulses.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bpu_wb <= 1'b0;
      {bpu_wb_is_bcc, bpu_wb_is_breg, bpu_wb_is_brel, bpu_wb_taken,
       bpu_wb_pc, bpu_wb_npc_act, bpu_wb_upd_partial} <= '0;
    end else begin
      bpu_wb <= fifo_pop;
      if (fifo_pop) begin
        {bpu_wb_is_bcc, bpu_wb_is_breg, bpu_wb_is_brel, bpu_wb_taken,
         bpu_wb_pc, bpu_wb_npc_act, bpu_wb_upd_partial} <= fifo_head;
      end
    end
  end

`ifdef BPU_UPD_DROP_EN
  logic [NL-1:0] lane_drop;
  logic [16:0]   drop_sum;

  assign lane_drop = cmt_valid & lane_br & ~lane_push & {NL{cmt_ready & ~flush_req}};
  assign drop_sum  = {1'b0, drop_cnt} + 17'($countones(lane_drop));

  // Saturating count of branch updates lost to a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst) drop_cnt <= '0;
    else      drop_cnt <= drop_sum[16] ? 16'hffff : drop_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_bpu_upd_ctrl.sv
// tb/tb_bpu_upd_ctrl.sv - randomized self-checking bench for bpu_upd_ctrl against a queue model
module tb_bpu_upd_ctrl;
  import bpu_upd_ctrl_pkg::*;

  localparam int PHT_P  = 4;
  localparam int BTB_P  = 3;
  localparam int NL     = 2;
  localparam int D      = 4;
  localparam int SW     = 4;
  localparam int TAG_W  = PC_W - BTB_P;
  localparam int PART_W = UPD_PART_W;
  localparam int PW     = 4 + TAG_W + PC_W + PART_W;
  typedef logic [PW-1:0] pay_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 flush_req = 1'b0;
  logic [NL-1:0]        cmt_valid = '0, cmt_is_bcc = '0, cmt_is_breg = '0, cmt_is_brel = '0, cmt_taken = '0;
  logic [NL*TAG_W-1:0]  cmt_pc = '0;
  logic [NL*PC_W-1:0]   cmt_npc_act = '0;
  logic [NL*PART_W-1:0] cmt_upd = '0;
  logic                 cmt_ready, bpu_wb, bpu_wb_is_bcc, bpu_wb_is_breg, bpu_wb_is_brel, bpu_wb_taken;
  logic [TAG_W-1:0]     bpu_wb_pc;
  logic [PC_W-1:0]      bpu_wb_npc_act;
  logic [PART_W-1:0]    bpu_wb_upd_partial;
  logic                 init_we, init_pht_we, init_btb_we, bpu_busy;
  logic [SW-1:0]        init_addr;
`ifdef BPU_UPD_DROP_EN
  logic [15:0]          drop_cnt;
`endif

  always #5 clk = ~clk;

  bpu_upd_ctrl #(
    .CONFIG_PHT_P_NUM(PHT_P), .CONFIG_BTB_P_NUM(BTB_P),
    .CONFIG_P_COMMIT_WIDTH(1), .CONFIG_P_UPD_FIFO(2)
  ) dut (
    .clk(clk), .rst(rst), .flush_req(flush_req),
    .cmt_valid(cmt_valid), .cmt_is_bcc(cmt_is_bcc), .cmt_is_breg(cmt_is_breg),
    .cmt_is_brel(cmt_is_brel), .cmt_taken(cmt_taken), .cmt_pc(cmt_pc),
    .cmt_npc_act(cmt_npc_act), .cmt_upd(cmt_upd), .cmt_ready(cmt_ready),
    .bpu_wb(bpu_wb), .bpu_wb_is_bcc(bpu_wb_is_bcc), .bpu_wb_is_breg(bpu_wb_is_breg),
    .bpu_wb_is_brel(bpu_wb_is_brel), .bpu_wb_taken(bpu_wb_taken), .bpu_wb_pc(bpu_wb_pc),
    .bpu_wb_npc_act(bpu_wb_npc_act), .bpu_wb_upd_partial(bpu_wb_upd_partial),
    .init_we(init_we), .init_pht_we(init_pht_we), .init_btb_we(init_btb_we),
    .init_addr(init_addr), .bpu_busy(bpu_busy)
`ifdef BPU_UPD_DROP_EN
    , .drop_cnt(drop_cnt)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of pending updates plus clear progress.
  bit   m_clear;
  int   m_idx;
  pay_t m_q[$];
  int   m_drop;
  bit   e_wb, e_we, e_pht, e_btb, e_busy;
  int   e_addr;
  pay_t e_pay;
  logic dut_rdy;

  task automatic model_reset();
    m_clear = 1'b1; m_idx = 0; m_q.delete(); m_drop = 0;
    e_wb = 1'b0; e_we = 1'b0; e_pht = 1'b0; e_btb = 1'b0; e_busy = 1'b1;
    e_addr = 0; e_pay = '0;
  endtask

  function automatic bit exp_ready();
`ifdef BPU_UPD_DROP_EN
    return !m_clear;
`else
    return !m_clear && ((D - m_q.size()) >= NL) && !flush_req;
`endif
  endfunction

  function automatic pay_t lane_pay(input int i);
    return {cmt_is_bcc[i], cmt_is_breg[i], cmt_is_brel[i], cmt_taken[i],
            cmt_pc[i*TAG_W +: TAG_W], cmt_npc_act[i*PC_W +: PC_W], cmt_upd[i*PART_W +: PART_W]};
  endfunction

  task automatic idle_in();
    cmt_valid = '0; cmt_is_bcc = '0; cmt_is_breg = '0; cmt_is_brel = '0; cmt_taken = '0;
    cmt_pc = '0; cmt_npc_act = '0; cmt_upd = '0; flush_req = 1'b0;
  endtask

  task automatic rand_in(input int vpct, input int fl_per);
    logic [2:0] f;
    for (int i = 0; i < NL; i++) begin
      cmt_valid[i] = ($urandom_range(99) < vpct);
      f = 3'($urandom_range(7));
      cmt_is_bcc[i] = f[0]; cmt_is_breg[i] = f[1]; cmt_is_brel[i] = f[2];
      cmt_taken[i] = 1'($urandom_range(1));
      cmt_pc[i*TAG_W +: TAG_W]     = TAG_W'($urandom);
      cmt_npc_act[i*PC_W +: PC_W]  = PC_W'($urandom);
      cmt_upd[i*PART_W +: PART_W]  = PART_W'($urandom);
    end
    flush_req = (fl_per > 0) && ($urandom_range(fl_per - 1) == 0);
  endtask

  // One clock: inputs already driven after negedge; check comb, advance model, check registers.
  task automatic cyc();
    bit   rdy, was_clear;
    int   room;
    #1;
    rdy = exp_ready();
    dut_rdy = cmt_ready;
    chk("cmt_ready", 128'(cmt_ready), 128'(rdy));
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      was_clear = m_clear;
      e_we   = was_clear;
      e_addr = was_clear ? m_idx : 0;
      e_pht  = was_clear && (m_idx < (1 << PHT_P));
      e_btb  = was_clear && (m_idx < (1 << BTB_P));
      e_wb   = 1'b0;
      if (was_clear) begin
        if (flush_req) m_idx = 0;
        else if (m_idx == (1 << SW) - 1) begin m_clear = 1'b0; m_idx = 0; end
        else m_idx++;
      end else if (flush_req) begin
        m_q.delete(); m_clear = 1'b1; m_idx = 0;
      end else begin
        room = D - m_q.size();
        if (m_q.size() > 0) begin e_wb = 1'b1; e_pay = m_q.pop_front(); end
        if (rdy) begin
          for (int i = 0; i < NL; i++) begin
            if (cmt_valid[i] && (cmt_is_bcc[i] || cmt_is_breg[i] || cmt_is_brel[i])) begin
              if (room > 0) begin m_q.push_back(lane_pay(i)); room--; end
              else if (m_drop < 65535) m_drop++;
            end
          end
        end
      end
      e_busy = was_clear || m_clear;
    end
    #1;
    chk("bpu_wb", 128'(bpu_wb), 128'(e_wb));
    chk("wb_payload", 128'({bpu_wb_is_bcc, bpu_wb_is_breg, bpu_wb_is_brel, bpu_wb_taken,
                            bpu_wb_pc, bpu_wb_npc_act, bpu_wb_upd_partial}), 128'(e_pay));
    chk("init_we", 128'(init_we), 128'(e_we));
    chk("init_addr", 128'(init_addr), 128'(e_addr));
    chk("init_pht_we", 128'(init_pht_we), 128'(e_pht));
    chk("init_btb_we", 128'(init_btb_we), 128'(e_btb));
    chk("bpu_busy", 128'(bpu_busy), 128'(e_busy));
`ifdef BPU_UPD_DROP_EN
    chk("drop_cnt", 128'(drop_cnt), 128'(m_drop));
`endif
  endtask

  initial begin
    int  nwb, k;
    bit  r, rdy_c2;
    model_reset();
    idle_in();
    rst = 1'b0;
    repeat (3) begin @(negedge clk); rand_in(80, 0); cyc(); end
    rst = 1'b1;
    repeat (18) begin @(negedge clk); rand_in(70, 0); cyc(); end
    repeat (6) begin @(negedge clk); idle_in(); cyc(); end

    // Single lane-0 update reaches bpu_wb one cycle after acceptance, once.
    @(negedge clk); idle_in();
    cmt_valid = 2'b01; cmt_is_bcc = 2'b01; cmt_taken = 2'b01;
    cmt_pc[TAG_W-1:0] = TAG_W'(8'h12);
    cyc();
    @(negedge clk); idle_in(); cyc();
    chk("lane0_wb", 128'(bpu_wb), 128'(1));
    chk("lane0_pc", 128'(bpu_wb_pc), 128'h12);
    chk("lane0_taken", 128'(bpu_wb_taken), 128'(1));
    @(negedge clk); idle_in(); cyc();
    chk("lane0_single", 128'(bpu_wb), 128'(0));

    // Both lanes for three accepted cycles: ready drops on the third, six pulses total.
    nwb = 0; k = 0; rdy_c2 = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (k < 3) begin rand_in(0, 0); cmt_valid = '1; cmt_is_bcc = '1; end
      else idle_in();
      r = exp_ready();
      cyc();
      if (c == 2) rdy_c2 = dut_rdy;
      if (k < 3 && r) k++;
      nwb += int'(bpu_wb);
    end
    chk("burst_accepts", 128'(k), 128'(3));
    chk("burst_ready_c2", 128'(rdy_c2), 128'(0));
    chk("burst_wb_count", 128'(nwb), 128'(6));

    // Flush with three entries queued: nothing further is written back.
    @(negedge clk); rand_in(0, 0); cmt_valid = '1; cmt_is_brel = '1; cyc();
    @(negedge clk); rand_in(0, 0); cmt_valid = '1; cmt_is_breg = '1; cyc();
    @(negedge clk); idle_in(); flush_req = 1'b1; cyc();
    nwb = 0;
    repeat (20) begin @(negedge clk); idle_in(); cyc(); nwb += int'(bpu_wb); end
    chk("flush_no_wb", 128'(nwb), 128'(0));

    repeat (400) begin @(negedge clk); rand_in(75, 40); cyc(); end

    // Reset in the middle of traffic, then a fresh clear.
    rst = 1'b0;
    repeat (2) begin @(negedge clk); rand_in(75, 0); cyc(); end
    rst = 1'b1;
    repeat (40) begin @(negedge clk); rand_in(75, 0); cyc(); end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bpu_upd_ctrl.md
Name: bpu_upd_ctrl

Overview:
Schedules branch-predictor training between the commit stage and the predictor's single PHT/BTB write port.
- Accepts up to 2^CONFIG_P_COMMIT_WIDTH resolved-branch updates per cycle.
- Buffers them in a small FIFO and issues at most one bpu_wb transaction per cycle.
- Owns the table-clear sequencer, which runs after reset and on flush; fetch is held off (bpu_busy) while it runs.

Parameters:
- CONFIG_PHT_P_NUM, 9, log2 PHT entries.
- CONFIG_BTB_P_NUM, 9, log2 BTB entries.
- CONFIG_P_COMMIT_WIDTH, 1, log2 commit lanes (NL = 2^value).
- CONFIG_P_UPD_FIFO, 2, log2 FIFO depth (D = 2^value, D >= NL required).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low.
- flush_req  in  1  pulse; re-clear tables (e.g. ASID/imme change).
- cmt_valid  in  NL  per-lane update valid.
- cmt_is_bcc, cmt_is_breg, cmt_is_brel, cmt_taken  in  NL each  per-lane branch info.
- cmt_pc  in  NL*(`PC_W-CONFIG_BTB_P_NUM)  per-lane tag PC.
- cmt_npc_act  in  NL*`PC_W  per-lane actual target.
- cmt_upd  in  NL*(`BPU_UPD_W-`BPU_UPD_TAKEN_TGT_W)  per-lane partial upd.
- cmt_ready  out  1  all lanes accepted this cycle.
- bpu_wb, bpu_wb_is_bcc, bpu_wb_is_breg, bpu_wb_is_brel, bpu_wb_taken  out  1 each  serialized update to predictor.
- bpu_wb_pc, bpu_wb_npc_act, bpu_wb_upd_partial  out  widths as cmt_*  serialized payload.
- init_we  out  1  table-clear write strobe.
- init_pht_we  out  1  clear write targets PHT.
- init_btb_we  out  1  clear write targets BTB.
- init_addr  out  SW = max(PHT_P_NUM, BTB_P_NUM)  clear index.
- bpu_busy  out  1  clear in progress; fetch must not assert re.

Behaviour:
- Reset (rst==0 at posedge): state=CLEAR, idx=0, FIFO empty, count=0. bpu_wb=0, cmt_ready=0, init_we=0, bpu_busy=1. All registered outputs read 0 except bpu_busy.
- FSM CLEAR:
  - Each cycle: init_we=1, init_addr=idx.
  - init_pht_we = idx < 2^PHT_P_NUM; init_btb_we = idx < 2^BTB_P_NUM.
  - Data is implied: PHT=2'b01 (weak not-taken), BTB v=0.
  - idx increments; at idx == 2^SW-1 go to RUN next cycle.
  - Duration exactly 2^SW cycles.
  - cmt_ready=0, bpu_wb=0, bpu_busy=1.
- FSM RUN: bpu_busy=0; FIFO operates.
  - flush_req in RUN: FIFO discarded, no bpu_wb that cycle, idx=0, next state CLEAR.
  - flush_req in CLEAR: restarts idx at 0.
- Accept rule:
  - cmt_ready = (state==RUN) & (D-count >= NL) & ~flush_req. Combinational, from registered count.
  - Accepted lanes are those with cmt_valid=1 and cmt_ready=1.
  - Valid lanes are compacted and enqueued in lane order, lane 0 first. count += popcount(valid).
  - Lanes with cmt_valid=0 are ignored; holes are not stored.
- Drain: when count>0 and state==RUN, the head pops each cycle into the output register.
  - bpu_wb=1 the next cycle with the head payload. Latency enqueue->bpu_wb >= 1 cycle.
  - Throughput is 1 update/cycle.
- Simultaneous enqueue and dequeue in one cycle: count = count + pushes - 1. Full-then-pop does not lose an entry.
- Pointers are SW-free modulo-D counters (wrap at D). count width CONFIG_P_UPD_FIFO+1.
- Ordering: updates reach bpu_wb in commit order (lane order within a cycle). GHSR consistency relies on this.
- Filter: lanes where none of is_bcc/is_breg/is_brel is set are accepted but not enqueued.

Optional Feature:
BPU_UPD_DROP_EN
- Defined: cmt_ready is 1 whenever state==RUN. Lanes that do not fit are dropped, youngest lanes first.
- Defined: a 16-bit saturating drop_cnt output port is added; it is cleared only on reset.
- Undefined: behaviour is backpressure as above, and the drop_cnt port is absent.

Decomposition:
- Shared config header (ncpu64k_config.vh):
  - PHT clear value 2'b01.
  - BPU update payload width macro BPU_UPD_PAYLOAD_W = 4 + tag + `PC_W + partial.
  - FSM state encodings BPU_UC_CLEAR=1'b0, BPU_UC_RUN=1'b1.
- Sub-module bpu_upd_fifo: multi-push (NL), single-pop, parameterized depth/width, with count output.

Test Plan:
- Reset release, PHT_P=BTB_P=4 -> init_we high for exactly 16 cycles, init_addr 0..15, then bpu_busy=0 and cmt_ready=1.
- Lane0 valid bcc taken, pc tag 0x12 -> next cycle bpu_wb=1, bpu_wb_pc=0x12, taken=1, single pulse.
- Both lanes valid for 3 consecutive cycles, D=4 -> cmt_ready drops after cycle 2. Six bpu_wb pulses occur in order lane0,lane1,... with no loss.
- Push 2 while count=2 with a pop in the same cycle -> count=3, cmt_ready=0 until count<=2.
- flush_req with count=3 -> no further bpu_wb, CLEAR runs 16 cycles, FIFO empty after.
- BPU_UPD_DROP_EN defined, FIFO full, 2 lanes valid -> cmt_ready=1, drop_cnt += 2, bpu_wb sequence unchanged.
